// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared op/condition encodings and condition evaluator for branch_unit
// Contents: op_e (branch op codes), cond_e (16 flag conditions), cond_eval() (condition -> taken).
package branch_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_JMP      = 3'd1,
    OP_JMP_REL  = 3'd2,
    OP_CALL     = 3'd3,
    OP_CALL_REL = 3'd4,
    OP_RET      = 3'd5
  } op_e;

  typedef enum logic [3:0] {
    COND_ALWAYS = 4'd0,
    COND_Z      = 4'd1,
    COND_NZ     = 4'd2,
    COND_C      = 4'd3,
    COND_C_OR_Z = 4'd4,
    COND_NC_NZ  = 4'd5,
    COND_NC     = 4'd6,
    COND_LT     = 4'd7,
    COND_LE     = 4'd8,
    COND_GT     = 4'd9,
    COND_GE     = 4'd10,
    COND_Z_ALT  = 4'd11,
    COND_O      = 4'd12,
    COND_C_ALT  = 4'd13,
    COND_S      = 4'd14,
    COND_NEVER  = 4'd15
  } cond_e;

  // Signed comparisons use O^S as "less than"; 11 and 13 duplicate Z and C
  // so older decoders keep their encodings.
  function automatic logic cond_eval(input cond_e cond, input logic z, input logic o,
                                     input logic c, input logic s);
    logic r;
    case (cond)
      COND_ALWAYS: r = 1'b1;
      COND_Z:      r = z;
      COND_NZ:     r = !z;
      COND_C:      r = c;
      COND_C_OR_Z: r = c | z;
      COND_NC_NZ:  r = !c & !z;
      COND_NC:     r = !c;
      COND_LT:     r = o ^ s;
      COND_LE:     r = (o ^ s) | z;
      COND_GT:     r = (o == s) & !z;
      COND_GE:     r = (o == s);
      COND_Z_ALT:  r = z;
      COND_O:      r = o;
      COND_C_ALT:  r = c;
      COND_S:      r = s;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_unit_if.sv
// rtl/branch_unit_if.sv - decoder <-> branch_unit request/result bundle
// master (decoder): drives req, op, cond, databus, hi_we, pcin, z/o/c/s flags, err_clr;
//                   receives valid, taken, pcout, ras_count, ras_ovf, ras_unf.
// slave (branch_unit): the reverse directions.
interface branch_unit_if #(
  parameter int PC_W      = 23,
  parameter int DATA_W    = 16,
  parameter int RAS_DEPTH = 8
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              req;
  logic [2:0]        op;
  logic [3:0]        cond;
  logic [DATA_W-1:0] databus;
  logic              hi_we;
  logic [PC_W-1:0]   pcin;
  logic              zflag;
  logic              oflag;
  logic              cflag;
  logic              sflag;
  logic              err_clr;
  logic              valid;
  logic              taken;
  logic [PC_W-1:0]   pcout;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_ovf;
  logic              ras_unf;

  modport master (
    output req, op, cond, databus, hi_we, pcin, zflag, oflag, cflag, sflag, err_clr,
    input  valid, taken, pcout, ras_count, ras_ovf, ras_unf
  );

  modport slave (
    input  req, op, cond, databus, hi_we, pcin, zflag, oflag, cflag, sflag, err_clr,
    output valid, taken, pcout, ras_count, ras_ovf, ras_unf
  );
endinterface

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack, oldest entry overwritten when full
// Ports: clk, rst (async, active-high); push, pop, push_data in;
//        top_data (most recent entry), count (occupancy), full, empty out.
module ras_stack #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp;       // next free slot; wraps, so when full it names the oldest entry
  logic [PW-1:0]    top_idx;

  assign top_idx  = sp - PW'(1);
  assign top_data = mem[top_idx];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[sp] <= push_data;
    end
  end

  // push has priority; pop on an empty stack is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
    end else if (push) begin
      sp <= sp + PW'(1);
      if (!full) begin
        count <= count + CW'(1);
      end
    end else if (pop && !empty) begin
      sp    <= sp - PW'(1);
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - conditional jump/call/return unit with high-word register and RAS
// Ports: clk, rst (async, active-high); bus (branch_unit_if.slave): request fields in,
//        registered valid/taken/pcout, ras_count and sticky ras_ovf/ras_unf out.
module branch_unit
  import branch_pkg::*;
#(
  parameter int PC_W      = 23,
  parameter int DATA_W    = 16,
  parameter int RAS_DEPTH = 8,
  parameter int CLEAR_HI  = 1
) (
  input  logic          clk,
  input  logic          rst,
  branch_unit_if.slave  bus
);
  localparam int AW = 2 * DATA_W;

  logic [DATA_W-1:0] hi_q;
  logic [AW-1:0]     addr_full;
  logic [PC_W-1:0]   target_abs;
  logic [PC_W-1:0]   target_rel;
  logic [PC_W-1:0]   target;

  logic is_jmp, is_call, is_ret, is_rel, cond_ok;
  logic do_push, do_pop, ovf_evt, unf_evt, taken_n, hi_clr;
  logic [PC_W-1:0] pcout_n;

  logic [PC_W-1:0] ras_top;
  logic            ras_full, ras_empty;

  logic            valid_q, taken_q, ovf_q, unf_q;
  logic [PC_W-1:0] pcout_q;

  // The cast truncates or zero-extends {hi, databus} to the PC width.
  assign addr_full  = {hi_q, bus.databus};
  assign target_abs = PC_W'(addr_full);
  assign target_rel = bus.pcin + target_abs;

  assign is_jmp  = (bus.op == OP_JMP)  || (bus.op == OP_JMP_REL);
  assign is_call = (bus.op == OP_CALL) || (bus.op == OP_CALL_REL);
  assign is_ret  = (bus.op == OP_RET);
  assign is_rel  = (bus.op == OP_JMP_REL) || (bus.op == OP_CALL_REL);
  assign target  = is_rel ? target_rel : target_abs;

  assign cond_ok = cond_eval(cond_e'(bus.cond), bus.zflag, bus.oflag, bus.cflag, bus.sflag);

  assign do_push = bus.req && is_call && cond_ok;
  assign do_pop  = bus.req && is_ret && cond_ok && !ras_empty;
  assign ovf_evt = do_push && ras_full;
  assign unf_evt = bus.req && is_ret && cond_ok && ras_empty;
  assign hi_clr  = (CLEAR_HI != 0) && bus.req && (is_jmp || is_call) && cond_ok;
  assign taken_n = (bus.req && (is_jmp || is_call) && cond_ok) || do_pop;

  always_comb begin
    pcout_n = '0;
    if (taken_n) begin
      pcout_n = is_ret ? ras_top : target;
    end
  end

  ras_stack #(
    .WIDTH (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (bus.pcin),
    .top_data  (ras_top),
    .count     (bus.ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // A same-cycle hi_we wins over the post-branch clear; the req itself saw the old hi_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
    end else if (bus.hi_we) begin
      hi_q <= bus.databus;
    end else if (hi_clr) begin
      hi_q <= '0;
    end
  end

  // Sticky errors: a new event in the err_clr cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      pcout_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      valid_q <= bus.req;
      taken_q <= taken_n;
      pcout_q <= pcout_n;
      ovf_q   <= ovf_evt | (ovf_q & !bus.err_clr);
      unf_q   <= unf_evt | (unf_q & !bus.err_clr);
    end
  end

  assign bus.valid   = valid_q;
  assign bus.taken   = taken_q;
  assign bus.pcout   = pcout_q;
  assign bus.ras_ovf = ovf_q;
  assign bus.ras_unf = unf_q;
endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - self-checking bench for branch_unit
module tb_branch_unit;
  localparam int PC_W      = 23;
  localparam int DATA_W    = 16;
  localparam int RAS_DEPTH = 8;
  localparam longint PC_MASK = (64'd1 << PC_W) - 1;

  localparam int NOP = 0, JMP = 1, JMP_REL = 2, CALL = 3, CALL_REL = 4, RET = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W), .RAS_DEPTH(RAS_DEPTH)) bif ();

  branch_unit #(
    .PC_W(PC_W), .DATA_W(DATA_W), .RAS_DEPTH(RAS_DEPTH), .CLEAR_HI(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  typedef struct {
    int     op;
    int     cond;
    bit     z, o, c, s;
    longint db;
    longint pcin;
    bit     exp_taken;
    longint exp_pcout;
  } vec_t;

  vec_t tbl[10];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  longint m_hi;
  longint m_ras[$];
  bit     m_ovf, m_unf;
  bit     e_valid, e_taken;
  longint e_pcout;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic bit m_cond(input int c, input bit z, input bit o, input bit cf, input bit s);
    case (c)
      0: return 1;
      1, 11: return z;
      2: return !z;
      3, 13: return cf;
      4: return cf || z;
      5: return !cf && !z;
      6: return !cf;
      7: return o != s;
      8: return (o != s) || z;
      9: return (o == s) && !z;
      10: return o == s;
      12: return o;
      14: return s;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_hi = 0; m_ras.delete(); m_ovf = 0; m_unf = 0;
    e_valid = 0; e_taken = 0; e_pcout = 0;
  endtask

  // Advances the model by one clock edge using the stimulus the bench applied.
  task automatic model_edge(input bit req, input int op, input int cond, input longint db,
                            input longint pcin, input bit hi_we, input bit z, input bit o,
                            input bit c, input bit s, input bit ec);
    bit ok, clr;
    longint addr, tgt;
    e_valid = req; e_taken = 0; e_pcout = 0; clr = 0;
    if (ec) begin m_ovf = 0; m_unf = 0; end
    if (req) begin
      ok   = m_cond(cond, z, o, c, s);
      addr = m_hi * 65536 + db;
      tgt  = (op == JMP_REL || op == CALL_REL) ? ((pcin + addr) & PC_MASK) : (addr & PC_MASK);
      if (ok && (op == JMP || op == JMP_REL)) begin
        e_taken = 1; e_pcout = tgt; clr = 1;
      end else if (ok && (op == CALL || op == CALL_REL)) begin
        if (m_ras.size() == RAS_DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
        m_ras.push_back(pcin);
        e_taken = 1; e_pcout = tgt; clr = 1;
      end else if (ok && op == RET) begin
        if (m_ras.size() == 0) m_unf = 1;
        else begin e_taken = 1; e_pcout = m_ras.pop_back(); end
      end
    end
    if (hi_we) m_hi = db;
    else if (clr) m_hi = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, bif.valid, e_valid);
    chk({tag, ".taken"}, bif.taken, e_taken);
    chk({tag, ".pcout"}, bif.pcout, e_pcout);
    chk({tag, ".ras_count"}, bif.ras_count, m_ras.size());
    chk({tag, ".ras_ovf"}, bif.ras_ovf, m_ovf);
    chk({tag, ".ras_unf"}, bif.ras_unf, m_unf);
  endtask

  task automatic drive(input bit req, input int op, input int cond, input longint db,
                       input longint pcin, input bit hi_we, input bit z, input bit o,
                       input bit c, input bit s, input bit ec);
    bif.req = req; bif.op = 3'(op); bif.cond = 4'(cond); bif.databus = DATA_W'(db);
    bif.pcin = PC_W'(pcin); bif.hi_we = hi_we; bif.zflag = z; bif.oflag = o;
    bif.cflag = c; bif.sflag = s; bif.err_clr = ec;
  endtask

  // Called at a negedge; applies one cycle of stimulus and checks the registered result.
  task automatic run(input string tag, input bit req, input int op, input int cond,
                     input longint db, input longint pcin, input bit hi_we, input bit z,
                     input bit o, input bit c, input bit s, input bit ec);
    drive(req, op, cond, db, pcin, hi_we, z, o, c, s, ec);
    model_edge(req, op, cond, db, pcin, hi_we, z, o, c, s, ec);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{JMP,      4, 0, 0, 1, 0, 'h1111, 0,        1, 'h001111};
    tbl[1] = '{JMP,      5, 0, 0, 1, 0, 'h2222, 0,        0, 0};
    tbl[2] = '{JMP,      7, 0, 1, 0, 0, 'h3333, 0,        1, 'h003333};
    tbl[3] = '{JMP,     10, 0, 1, 0, 0, 'h4444, 0,        0, 0};
    tbl[4] = '{JMP,     15, 1, 1, 1, 1, 'h5555, 0,        0, 0};
    tbl[5] = '{NOP,      0, 0, 0, 0, 0, 'h6666, 0,        0, 0};
    tbl[6] = '{7,        0, 0, 0, 0, 0, 'h7777, 0,        0, 0};
    tbl[7] = '{JMP_REL,  0, 0, 0, 0, 0, 'h0020, 'h7FFFF0, 1, 'h000010};
    tbl[8] = '{JMP,      9, 0, 1, 0, 1, 'h0099, 0,        1, 'h000099};
    tbl[9] = '{JMP,      8, 1, 0, 0, 0, 'h0088, 0,        1, 'h000088};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.valid", bif.valid, 0);
    chk("reset.taken", bif.taken, 0);
    chk("reset.pcout", bif.pcout, 0);
    chk("reset.ras_count", bif.ras_count, 0);
    chk("reset.ras_ovf", bif.ras_ovf, 0);
    chk("reset.ras_unf", bif.ras_unf, 0);
    rst = 1'b0;

    // Absolute target from the high word, then high word cleared by the taken JMP
    run("hi_load", 0, NOP, 0, 'h0012, 0, 1, 0, 0, 0, 0, 0);
    run("jmp_abs", 1, JMP, 0, 'h3456, 0, 0, 0, 0, 0, 0, 0);
    chk("jmp_abs.pcout_const", bif.pcout, 'h123456);
    run("hi_cleared", 1, JMP, 0, 'h0001, 0, 0, 0, 0, 0, 0, 0);
    chk("hi_cleared.pcout_const", bif.pcout, 'h000001);

    foreach (tbl[i]) begin
      run($sformatf("tbl%0d", i), 1, tbl[i].op, tbl[i].cond, tbl[i].db, tbl[i].pcin, 0,
          tbl[i].z, tbl[i].o, tbl[i].c, tbl[i].s, 0);
      chk($sformatf("tbl%0d.taken_const", i), bif.taken, tbl[i].exp_taken);
      chk($sformatf("tbl%0d.pcout_const", i), bif.pcout, tbl[i].exp_pcout);
    end

    // Nine CALLs overflow an 8-deep stack; RETs unwind 9..2, then underflow
    for (int i = 1; i <= 9; i++) run("call", 1, CALL, 0, 'h0100, i, 0, 0, 0, 0, 0, 0);
    chk("call.count_full", bif.ras_count, RAS_DEPTH);
    chk("call.ovf_const", bif.ras_ovf, 1);
    for (int k = 0; k < 8; k++) begin
      run("ret", 1, RET, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("ret%0d.pcout_const", k), bif.pcout, 9 - k);
    end
    chk("ret.count_empty", bif.ras_count, 0);
    run("ret_unf", 1, RET, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ret_unf.taken_const", bif.taken, 0);
    chk("ret_unf.unf_const", bif.ras_unf, 1);

    // err_clr coinciding with a fresh underflow keeps the flag, then a plain clear
    run("errclr_vs_evt", 1, RET, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("errclr_vs_evt.unf_const", bif.ras_unf, 1);
    run("errclr", 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("errclr.ovf_const", bif.ras_ovf, 0);
    chk("errclr.unf_const", bif.ras_unf, 0);
    run("errclr_clean", 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // hi_we in the same cycle as a taken JMP: old high word used, new value kept
    run("hi_same", 1, JMP, 0, 'h0005, 0, 1, 0, 0, 0, 0, 0);
    chk("hi_same.pcout_const", bif.pcout, 'h000005);
    run("hi_after", 1, JMP, 0, 'h0001, 0, 0, 0, 0, 0, 0, 0);
    chk("hi_after.pcout_const", bif.pcout, 'h050001);

    // Reset landing on a req cycle with a full stack and a sticky flag
    for (int i = 0; i < 9; i++) run("prefill", 1, CALL_REL, 0, i, 'h40, 0, 0, 0, 0, 0, 0);
    drive(1, JMP, 0, 'h1234, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.valid", bif.valid, 0);
    chk("midrst.taken", bif.taken, 0);
    chk("midrst.pcout", bif.pcout, 0);
    chk("midrst.ras_count", bif.ras_count, 0);
    chk("midrst.ras_ovf", bif.ras_ovf, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    run("post_rst", 0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 500; n++) begin
      run("rand", ($urandom_range(3) != 0), $urandom_range(7), $urandom_range(15),
          $urandom_range(16'hFFFF), $urandom & PC_MASK, ($urandom_range(3) == 0),
          $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
          ($urandom_range(15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
